// File: rtl/modulo_pkg.sv
// Shared definitions for the modulo engine: FSM state encoding and the
// sizing rule for the iteration counter.
package modulo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence clog2(WIDTH+1).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/modulo_step.sv
// One restoring shift-subtract step: shift the next dividend bit into the
// partial remainder, try to subtract the divisor and restore on borrow.
module modulo_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] diff;
  logic             borrow;

  // The extra top bit of diff is the borrow of the (WIDTH+1)-bit subtract.
  assign diff    = {rem_in, bit_in} - {2'b00, divisor};
  assign borrow  = diff[WIDTH+1];
  assign q_bit   = ~borrow;

  // Keep the shifted value when the subtract would go negative.
  assign rem_out = borrow ? {rem_in[WIDTH-1:0], bit_in} : diff[WIDTH:0];

endmodule

// File: rtl/modulo_engine.sv
// Sequential unsigned modulo engine, one quotient bit per clock.
// Optional build macro MODULO_QUOTIENT_EN adds the quotient_o output.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready_o=1, waiting for start_i
// ITER    | busy, WIDTH shift-subtract steps counted down by cnt
// DONE    | valid_o=1, result held until ack_i
module modulo_engine
  import modulo_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] remainder_o,
`ifdef MODULO_QUOTIENT_EN
  output logic [WIDTH-1:0] quotient_o,
`endif
  output logic             err_o
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  modulo_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .bit_in  (q_r[WIDTH-1]),
    .divisor (div_r),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Control FSM with registered outputs; q_r shifts dividend bits out and
  // quotient bits in from the bottom.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      div_r       <= '0;
      ready_o     <= 1'b1;
      valid_o     <= 1'b0;
      remainder_o <= '0;
      err_o       <= 1'b0;
`ifdef MODULO_QUOTIENT_EN
      quotient_o  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            ready_o <= 1'b0;
            div_r   <= divisor_i;
            q_r     <= dividend_i;
            rem_r   <= '0;
            if (divisor_i == '0) begin
              // Divide by zero skips iteration entirely.
              state       <= ST_DONE;
              valid_o     <= 1'b1;
              err_o       <= 1'b1;
              remainder_o <= dividend_i;
`ifdef MODULO_QUOTIENT_EN
              quotient_o  <= '1;
`endif
            end else begin
              state <= ST_ITER;
              cnt   <= CW'(WIDTH);
            end
          end
        end
        ST_ITER: begin
          rem_r <= step_rem;
          q_r   <= {q_r[WIDTH-2:0], step_q};
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= ST_DONE;
            valid_o     <= 1'b1;
            remainder_o <= step_rem[WIDTH-1:0];
`ifdef MODULO_QUOTIENT_EN
            quotient_o  <= {q_r[WIDTH-2:0], step_q};
`endif
          end
        end
        ST_DONE: begin
          if (ack_i) begin
            state       <= ST_IDLE;
            ready_o     <= 1'b1;
            valid_o     <= 1'b0;
            remainder_o <= '0;
            err_o       <= 1'b0;
`ifdef MODULO_QUOTIENT_EN
            quotient_o  <= '0;
`endif
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
